rd_pntrs_and_empty: RTL and testbench

Read-side pointer and status stage of the dual-clock FIFO. It is the read-domain mirror of the write pointer/full block.
- Synchronises the write domain's registered Gray write pointer into rd_clk_i.
- Maintains the binary and Gray read pointers.
- Drives the RAM read address, a registered empty flag and a registered used-words count.
- Its registered Gray read pointer is the rd_pntr_gray input consumed by the write side.

---
 rtl/rd_pntrs_and_empty.sv | 82 ++++++++
 tb/tb_rd_pntrs_and_empty.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rd_pntrs_and_empty.sv
// Read-side pointer and status stage of the dual-clock FIFO: write-pointer synchroniser,
// binary/Gray read pointers, empty flag and used-words count. `RD_ALMOST_EMPTY_EN adds rd_almost_empty_o.
module rd_pntrs_and_empty #(
  parameter int AWIDTH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_LEVEL    = 2
) (
  input  logic              rd_clk_i,
  input  logic              aclr_i,
  input  logic              rd_req_i,
  input  logic [AWIDTH:0]   wr_pntr_gray,
  output logic [AWIDTH-1:0] rd_pntr,
  output logic [AWIDTH:0]   rd_pntr_gray_wr,
  output logic              rd_empty_o,
  output logic [AWIDTH:0]   rd_usedw_o
`ifdef RD_ALMOST_EMPTY_EN
  ,
  output logic              rd_almost_empty_o
`endif
);

  localparam int PW = AWIDTH + 1;
  typedef logic [PW-1:0] ptr_t;

  // Bit i of the binary value is the XOR of all Gray bits from the MSB down to i.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    for (int i = 0; i < PW; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
  ptr_t wr_gray_s;
  ptr_t wr_bin_s;
  ptr_t rd_pntr_bin;
  ptr_t rd_pntr_bin_next;
  ptr_t rd_pntr_gray_next;
  ptr_t usedw_next;
  logic rd_accept;

  // Plain flop chain: any logic between stages would defeat metastability settling.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge rd_clk_i or negedge aclr_i) begin
    if (!aclr_i) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], wr_pntr_gray};
  end

  assign wr_gray_s = sync_q[SYNC_STAGES-1];
  assign wr_bin_s  = gray2bin(wr_gray_s);

  assign rd_accept         = rd_req_i & ~rd_empty_o;
  assign rd_pntr_bin_next  = rd_pntr_bin + ptr_t'(rd_accept);
  assign rd_pntr_gray_next = rd_pntr_bin_next ^ (rd_pntr_bin_next >> 1);
  assign usedw_next        = wr_bin_s - rd_pntr_bin_next;

  // Status looks at the post-read pointer so draining the last word flags empty on that same edge.
  always_ff @(posedge rd_clk_i or negedge aclr_i) begin
    if (!aclr_i) begin
      rd_pntr_bin     <= '0;
      rd_pntr_gray_wr <= '0;
      rd_empty_o      <= 1'b1;
      rd_usedw_o      <= '0;
    end else begin
      rd_pntr_bin     <= rd_pntr_bin_next;
      rd_pntr_gray_wr <= rd_pntr_gray_next;
      rd_empty_o      <= (rd_pntr_gray_next == wr_gray_s);
      rd_usedw_o      <= usedw_next;
    end
  end

  assign rd_pntr = rd_pntr_bin[AWIDTH-1:0];

`ifdef RD_ALMOST_EMPTY_EN
  localparam ptr_t AE_THRESH = ptr_t'(AE_LEVEL);

  always_ff @(posedge rd_clk_i or negedge aclr_i) begin
    if (!aclr_i) rd_almost_empty_o <= 1'b1;
    else         rd_almost_empty_o <= (usedw_next <= AE_THRESH);
  end
`endif

endmodule

// File: tb/tb_rd_pntrs_and_empty.sv
// Directed bench for rd_pntrs_and_empty: a count-based FIFO model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_rd_pntrs_and_empty;
  localparam int AW = 4;
  localparam int SS = 2;
  localparam int AE = 2;
  localparam int PW = AW + 1;
  localparam int MOD = 1 << PW;

  logic          clk  = 1'b0;
  logic          aclr = 1'b0;
  logic          req  = 1'b0;
  logic [PW-1:0] wgray = '0;
  logic [AW-1:0] rd_pntr;
  logic [PW-1:0] rd_gray;
  logic          empty;
  logic [PW-1:0] usedw;
  logic          ae;

  always #5 clk = ~clk;

  rd_pntrs_and_empty #(.AWIDTH(AW), .SYNC_STAGES(SS), .AE_LEVEL(AE)) dut (
    .rd_clk_i        (clk),
    .aclr_i          (aclr),
    .rd_req_i        (req),
    .wr_pntr_gray    (wgray),
    .rd_pntr         (rd_pntr),
    .rd_pntr_gray_wr (rd_gray),
    .rd_empty_o      (empty),
    .rd_usedw_o      (usedw)
`ifdef RD_ALMOST_EMPTY_EN
    ,
    .rd_almost_empty_o (ae)
`endif
  );

`ifndef RD_ALMOST_EMPTY_EN
  assign ae = 1'b1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gray(input int n);
    return (n ^ (n >> 1)) & (MOD - 1);
  endfunction

  function automatic int g2n(input logic [PW-1:0] g);
    for (int n = 0; n < MOD; n++) if (gray(n) == int'(g)) return n;
    return 0;
  endfunction

  // Model: counts of words written (as seen after the synchroniser delay) and words read.
  int hist[SS];
  int m_rd, m_usedw, seen;
  bit m_empty, m_ae;

  always @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      for (int i = 0; i < SS; i++) hist[i] = 0;
      m_rd = 0; m_usedw = 0; m_empty = 1'b1; m_ae = 1'b1;
    end else begin
      seen = hist[SS-1];
      for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = g2n(wgray);
      if (req && !m_empty) m_rd = (m_rd + 1) % MOD;
      m_usedw = (seen - m_rd + MOD) % MOD;
      m_empty = (m_usedw == 0);
      m_ae    = (m_usedw <= AE);
    end
  end

  always @(posedge clk) begin
    #1;
    check("cyc_empty", empty, m_empty);
    check("cyc_usedw", usedw, m_usedw);
    check("cyc_rd_pntr", rd_pntr, m_rd % (1 << AW));
    check("cyc_rd_gray", rd_gray, gray(m_rd));
`ifdef RD_ALMOST_EMPTY_EN
    check("cyc_almost_empty", ae, m_ae);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_wr(input int n);
    wgray = PW'(gray(n % MOD));
  endtask

  initial begin
    set_wr(0);
    repeat (2) tick();
    check("rst_empty", empty, 1);
    check("rst_usedw", usedw, 0);
    check("rst_rd_pntr", rd_pntr, 0);
    check("rst_rd_gray", rd_gray, 0);
    check("rst_almost_empty", ae, 1);
    aclr = 1'b1;

    // Reads while empty are ignored.
    req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("idle_empty", empty, 1);
      check("idle_rd_pntr", rd_pntr, 0);
      check("idle_usedw", usedw, 0);
      check("idle_rd_gray", rd_gray, 0);
    end

    // One word: visible on the third edge, consumed on the fourth.
    set_wr(1);
    tick(); check("lat_edge1_empty", empty, 1);
    tick(); check("lat_edge2_empty", empty, 1);
    tick(); check("lat_edge3_empty", empty, 0);
    check("lat_edge3_usedw", usedw, 1);
    tick();
    check("rd1_rd_pntr", rd_pntr, 1);
    check("rd1_rd_gray", rd_gray, 5'b00001);
    check("rd1_empty", empty, 1);
    check("rd1_usedw", usedw, 0);
    req = 1'b0;

    // Full FIFO from a fresh reset, then drain.
    aclr = 1'b0;
    tick();
    aclr = 1'b1;
    set_wr(16);
    repeat (3) tick();
    check("full_usedw", usedw, 16);
    check("full_empty", empty, 0);
    req = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("drain_usedw", usedw, 16 - k);
      check("drain_empty", empty, (k == 16) ? 1 : 0);
    end
    tick();
    check("extra_req_rd_pntr", rd_pntr, 0);
    check("extra_req_rd_gray", rd_gray, 5'b11000);
    check("extra_req_usedw", usedw, 0);

    // Wrap: write pointer steps to 35 while reading continuously.
    for (int n = 17; n <= 35; n++) begin
      set_wr(n);
      tick();
      check("wrap_usedw_bound", usedw <= 16, 1);
    end
    repeat (8) tick();
    check("wrap_rd_pntr", rd_pntr, 3);
    check("wrap_rd_gray", rd_gray, 5'b00010);
    check("wrap_empty", empty, 1);
    check("wrap_usedw", usedw, 0);

    // Simultaneous write arrival and read keeps usedw steady.
    req = 1'b0;
    set_wr(39);
    repeat (3) tick();
    check("sim_pre_usedw", usedw, 4);
    set_wr(40);
    tick();
    tick();
    req = 1'b1;
    tick();
    check("sim_usedw", usedw, 4);
    check("sim_rd_pntr", rd_pntr, 4);
    tick();
    check("ae_usedw3", usedw, 3);
`ifdef RD_ALMOST_EMPTY_EN
    check("ae_at3", ae, 0);
`endif
    tick();
    check("ae_usedw2", usedw, 2);
`ifdef RD_ALMOST_EMPTY_EN
    check("ae_at2", ae, 1);
`endif

    // Asynchronous reset between edges in the middle of a burst.
    set_wr(45);
    repeat (4) tick();
    #2;
    aclr = 1'b0;
    #1;
    check("arst_empty", empty, 1);
    check("arst_usedw", usedw, 0);
    check("arst_rd_pntr", rd_pntr, 0);
    check("arst_rd_gray", rd_gray, 0);
    check("arst_almost_empty", ae, 1);
    set_wr(0);
    tick();
    aclr = 1'b1;
    repeat (2) tick();
    check("post_rst_empty", empty, 1);
    check("post_rst_rd_pntr", rd_pntr, 0);
    set_wr(1);
    repeat (3) tick();
    check("post_rst_wr_empty", empty, 0);
    check("post_rst_wr_usedw", usedw, 1);
    tick();
    check("post_rst_rd_pntr1", rd_pntr, 1);
    check("post_rst_rd_empty", empty, 1);
    req = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
